// File: rtl/serial_product_collector.sv
// Assembles the LSB-first serial product stream of the shift-add multiplier into
// a parallel word and offers it on a valid/ready handshake with overrun tracking.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no frame open; ser_valid ignored, waiting for start
// COLLECT | frame open; each ser_valid cycle shifts one product bit in
module serial_product_collector #(
    parameter int n          = 32,
    parameter int FRAME_BITS = 2 * n,
    localparam int CW        = $clog2(FRAME_BITS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ser_in,
    input  logic              ser_valid,
    output logic [2*n-1:0]    product,
    output logic              prod_valid,
    input  logic              prod_ready,
    output logic              busy,
    output logic              overrun,
    output logic [CW-1:0]     bit_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

    state_t                  state, state_nx;
    logic [FRAME_BITS-1:0]   sr, sr_nx, sr_shift, sr_top;
    logic [2*n-1:0]          prod_nx, prod_load;
    logic [CW-1:0]           cnt_nx;
    logic                    pv_nx, ov_nx;
    logic                    shift_en, frame_done, xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            product    <= '0;
            prod_valid <= 1'b0;
            overrun    <= 1'b0;
            bit_count  <= '0;
        end else begin
            state      <= state_nx;
            sr         <= sr_nx;
            product    <= prod_nx;
            prod_valid <= pv_nx;
            overrun    <= ov_nx;
            bit_count  <= cnt_nx;
        end
    end

    // New bit enters at the top so the first bit received lands in bit 0
    // once FRAME_BITS bits have been shifted through.
    always_comb begin
        sr_top                 = '0;
        sr_top[FRAME_BITS-1]   = ser_in;
        sr_shift               = sr_top | (sr >> 1);
        prod_load              = '0;
        prod_load[FRAME_BITS-1:0] = sr_shift;
    end

    assign shift_en   = (state == COLLECT) && ser_valid && !start;
    assign frame_done = shift_en && (bit_count == LAST_BIT);
    assign xfer       = prod_valid && prod_ready;
    assign busy       = (state == COLLECT);

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = bit_count;
        prod_nx  = product;
        pv_nx    = prod_valid;
        ov_nx    = overrun;

        if (xfer) begin
            pv_nx = 1'b0;
        end

        // start outranks a completing frame: the frame in flight is discarded
        if (start) begin
            state_nx = COLLECT;
            sr_nx    = '0;
            cnt_nx   = '0;
            ov_nx    = 1'b0;
        end else if (shift_en) begin
            sr_nx = sr_shift;
            if (frame_done) begin
                state_nx = IDLE;
                cnt_nx   = '0;
                if (!prod_valid || prod_ready) begin
                    prod_nx = prod_load;
                    pv_nx   = 1'b1;
                end else begin
                    ov_nx = 1'b1;
                end
            end else begin
                cnt_nx = bit_count + CW'(1);
            end
        end
    end

endmodule
